// File: rtl/alu_cmd_deserializer.sv
// alu_cmd_deserializer
//   Front end of the serial ALU. Deframes 11-bit byte frames from SIN
//   (START=0, TYPE, 8 data bits MSB first, STOP=1), assembles N_OPS operands
//   of DATA_W bits followed by a CTL byte {x, OP[2:0], CRC[3:0]}, checks CRC4
//   (x^4+x+1, init 0) and presents one command per valid/ready transaction.
//
// Ports
//   CLK        clock, SIN sampled on rising edge
//   RST        synchronous active-high reset, aborts any partial frame
//   SIN        serial input, idles high
//   CMD_VALID  output register holds a command
//   CMD_READY  core accepts the command when CMD_VALID && CMD_READY
//   CMD_OP     OP field of the CTL byte (0 for framing/data errors)
//   CMD_OPND   operands, op k at [k*DATA_W +: DATA_W]
//   CMD_ERR    {ERR_FRAME, ERR_CRC, ERR_DATA}, one-hot or zero
//   OVERRUN    1-cycle pulse: a completed command was dropped
//   BUSY       bit FSM is not idle
module alu_cmd_deserializer #(
  parameter int DATA_W = 32,
  parameter int N_OPS  = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    SIN,
  output logic                    CMD_VALID,
  input  logic                    CMD_READY,
  output logic [2:0]              CMD_OP,
  output logic [N_OPS*DATA_W-1:0] CMD_OPND,
  output logic [2:0]              CMD_ERR,
  output logic                    OVERRUN,
  output logic                    BUSY
);
  localparam int OPND_W = N_OPS * DATA_W;
  localparam int BPO    = DATA_W / 8;        // bytes per operand
  localparam int NB     = OPND_W / 8;        // DATA bytes per command
  localparam int CNT_W  = $clog2(NB + 1);

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_DATA, S_STOP} state_t;

  state_t              r_state, w_state_next;
  logic [2:0]          r_bit_cnt;
  logic                r_type;
  logic [7:0]          r_shift;
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [3:0]          r_crc;
  logic [OPND_W-1:0]   r_asm, w_asm_next;

  logic                r_cmd_valid;
  logic [2:0]          r_cmd_op;
  logic [OPND_W-1:0]   r_cmd_opnd;
  logic [2:0]          r_cmd_err;
  logic                r_overrun;

  logic                w_stop, w_full, w_byte_ok, w_done;
  logic [3:0]          w_crc_final;
  logic [2:0]          w_err, w_op;

  // One serial step of the MSB-first CRC4 LFSR.
  function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!SIN) w_state_next = S_TYPE;
      S_TYPE:  w_state_next = S_DATA;
      S_DATA:  if (r_bit_cnt == 3'd0) w_state_next = S_STOP;
      S_STOP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Byte/command completion decode, evaluated while the STOP bit is on SIN.
  // Every STOP ends a command except a well-framed DATA byte that still fits.
  always_comb begin
    w_stop      = (r_state == S_STOP);
    w_full      = (r_byte_cnt == CNT_W'(NB));
    w_byte_ok   = w_stop && SIN && !r_type && !w_full;
    w_done      = w_stop && !w_byte_ok;
    // Final CRC step over {1'b1, OP}.
    w_crc_final = crc_bit(r_crc, 1'b1);
    for (int i = 6; i >= 4; i--) w_crc_final = crc_bit(w_crc_final, r_shift[i]);
    w_err = 3'b000;
    if (!SIN)                          w_err = 3'b100;
    else if (!(r_type && w_full))      w_err = 3'b001;
    else if (w_crc_final != r_shift[3:0]) w_err = 3'b010;
    w_op = (w_err[2] || w_err[0]) ? 3'd0 : r_shift[6:4];
  end

  // Byte slot gi lands in operand gi/BPO, most significant byte first.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      localparam int OFS = (gi / BPO) * DATA_W + (BPO - 1 - (gi % BPO)) * 8;
      assign w_asm_next[OFS +: 8] =
        w_done ? 8'd0 :
        (w_byte_ok && r_byte_cnt == CNT_W'(gi)) ? r_shift : r_asm[OFS +: 8];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bit_cnt   <= 3'd0;
      r_type      <= 1'b0;
      r_shift     <= 8'd0;
      r_byte_cnt  <= '0;
      r_crc       <= 4'd0;
      r_asm       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= 3'd0;
      r_cmd_opnd  <= '0;
      r_cmd_err   <= 3'd0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_asm     <= w_asm_next;
      if (r_state == S_TYPE) begin
        r_type    <= SIN;
        r_bit_cnt <= 3'd7;
      end
      if (r_state == S_DATA) begin
        r_shift   <= {r_shift[6:0], SIN};
        r_bit_cnt <= r_bit_cnt - 3'd1;
        // A DATA byte may still turn out to be an error; the CRC is then
        // cleared at its STOP, so updating it unconditionally is safe.
        if (!r_type) r_crc <= crc_bit(r_crc, SIN);
      end
      if (w_byte_ok) r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      if (w_done) begin
        r_byte_cnt <= '0;
        r_crc      <= 4'd0;
        // Load if the output register is empty or being emptied this cycle.
        if (!r_cmd_valid || CMD_READY) begin
          r_cmd_valid <= 1'b1;
          r_cmd_op    <= w_op;
          r_cmd_opnd  <= r_asm;
          r_cmd_err   <= w_err;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_cmd_valid && CMD_READY) begin
        r_cmd_valid <= 1'b0;
      end
    end
  end

  assign CMD_VALID = r_cmd_valid;
  assign CMD_OP    = r_cmd_op;
  assign CMD_OPND  = r_cmd_opnd;
  assign CMD_ERR   = r_cmd_err;
  assign OVERRUN   = r_overrun;
  assign BUSY      = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_cmd_deserializer.sv
// Bench for alu_cmd_deserializer: two instances (32x2 and 16x4, both 64-bit
// operand buses). A reference model builds byte streams and CRCs by polynomial
// long division; expected commands go into per-instance queues and a monitor
// compares whenever a command is presented.
module tb_alu_cmd_deserializer;
  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] opnd;
    logic [2:0]  err;
  } exp_t;

  logic        CLK, RST;
  logic        sin_a, rdy_a, vld_a, ovr_a, busy_a;
  logic [2:0]  op_a, err_a;
  logic [63:0] opnd_a;
  logic        sin_b, rdy_b, vld_b, ovr_b, busy_b;
  logic [2:0]  op_b, err_b;
  logic [63:0] opnd_b;

  int checks = 0;
  int errors = 0;
  int ovr_cnt_a = 0;
  int ovr_cnt_b = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  alu_cmd_deserializer #(.DATA_W(32), .N_OPS(2)) dut_a (
    .CLK(CLK), .RST(RST), .SIN(sin_a), .CMD_VALID(vld_a), .CMD_READY(rdy_a),
    .CMD_OP(op_a), .CMD_OPND(opnd_a), .CMD_ERR(err_a), .OVERRUN(ovr_a), .BUSY(busy_a));

  alu_cmd_deserializer #(.DATA_W(16), .N_OPS(4)) dut_b (
    .CLK(CLK), .RST(RST), .SIN(sin_b), .CMD_VALID(vld_b), .CMD_READY(rdy_b),
    .CMD_OP(op_b), .CMD_OPND(opnd_b), .CMD_ERR(err_b), .OVERRUN(ovr_b), .BUSY(busy_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic int op_width(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  // i-th transmitted byte: operands in index order, each MSB byte first.
  function automatic logic [7:0] opnd_byte(input int d, input logic [63:0] opnd, input int i);
    int w, bpo, k, j;
    w = op_width(d); bpo = w / 8; k = i / bpo; j = i % bpo;
    return opnd[k*w + (bpo-1-j)*8 +: 8];
  endfunction

  // Operands as seen after only n bytes: each operand keeps its top received bytes.
  function automatic logic [63:0] partial(input int d, input logic [63:0] opnd, input int n);
    logic [63:0] r;
    int w, bpo, m;
    r = '0; w = op_width(d); bpo = w / 8;
    for (int k = 0; k < 64 / w; k++) begin
      m = n - k * bpo;
      if (m < 0) m = 0;
      if (m > bpo) m = bpo;
      for (int b = 0; b < w; b++)
        if (b >= w - 8 * m) r[k*w + b] = opnd[k*w + b];
    end
    return r;
  endfunction

  // CRC4 = (message * x^4) mod (x^4+x+1), message = operand bits, 1, OP.
  function automatic logic [3:0] crc_ref(input int d, input logic [63:0] opnd, input logic [2:0] op);
    bit msg[$];
    logic [7:0] by;
    logic [4:0] poly;
    int n;
    poly = 5'b10011;
    for (int i = 0; i < 8; i++) begin
      by = opnd_byte(d, opnd, i);
      for (int t = 7; t >= 0; t--) msg.push_back(by[t]);
    end
    msg.push_back(1'b1);
    for (int t = 2; t >= 0; t--) msg.push_back(op[t]);
    for (int t = 0; t < 4; t++) msg.push_back(1'b0);
    n = msg.size();
    for (int i = 0; i <= n - 5; i++)
      if (msg[i]) for (int t = 0; t < 5; t++) msg[i+t] = msg[i+t] ^ poly[4-t];
    return {msg[n-4], msg[n-3], msg[n-2], msg[n-1]};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) exp_a.push_back(e); else exp_b.push_back(e);
  endtask

  task automatic mon_check(input int d, input logic v, input logic rdy,
                           input logic [2:0] op, input logic [63:0] opnd, input logic [2:0] err);
    exp_t e;
    if (!v) return;
    checks++;
    if ((d == 0 ? exp_a.size() : exp_b.size()) == 0) begin
      errors++;
      $display("FAIL dut%0d_unexpected_cmd: got op=%0d err=%b opnd=%h, expected no command", d, op, err, opnd);
      return;
    end
    e = (d == 0) ? exp_a[0] : exp_b[0];
    if ({op, opnd, err} !== e) begin
      errors++;
      $display("FAIL dut%0d_cmd: got op=%0d err=%b opnd=%h, expected op=%0d err=%b opnd=%h",
               d, op, err, opnd, e.op, e.err, e.opnd);
    end
    if (rdy) begin
      $display("dut%0d accepted op=%0d err=%b opnd=%h", d, op, err, opnd);
      if (d == 0) void'(exp_a.pop_front()); else void'(exp_b.pop_front());
    end
  endtask

  // Monitor samples 1 time unit before each rising edge; inputs change 3 before.
  initial begin
    forever begin
      @(negedge CLK); #4;
      if (!RST) begin
        mon_check(0, vld_a, rdy_a, op_a, opnd_a, err_a);
        mon_check(1, vld_b, rdy_b, op_b, opnd_b, err_b);
        if (ovr_a) ovr_cnt_a++;
        if (ovr_b) ovr_cnt_b++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_bit(input int d, input logic b);
    @(negedge CLK); #2;
    if (d == 0) sin_a = b; else sin_b = b;
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) drive_bit(d, 1'b1);
  endtask

  task automatic send_byte(input int d, input logic typ, input logic [7:0] data, input logic stop_bit);
    drive_bit(d, 1'b0);
    drive_bit(d, typ);
    for (int i = 7; i >= 0; i--) drive_bit(d, data[i]);
    drive_bit(d, stop_bit);
  endtask

  task automatic send_cmd(input int d, input logic [63:0] opnd, input logic [2:0] op,
                          input bit bad_crc, input bit push);
    logic [3:0] crc;
    exp_t e;
    crc = crc_ref(d, opnd, op);
    if (bad_crc) crc[0] = ~crc[0];
    e.op = op; e.opnd = opnd; e.err = bad_crc ? 3'b010 : 3'b000;
    if (push) push_exp(d, e);
    for (int i = 0; i < 8; i++) send_byte(d, 1'b0, opnd_byte(d, opnd, i), 1'b1);
    send_byte(d, 1'b1, {1'($urandom_range(0, 1)), op, crc}, 1'b1);
  endtask

  // kind 0: CTL after n<8 DATA bytes; 1: extra DATA byte after 8;
  // 2: STOP=0 on byte index n (n==8 means the CTL byte).
  task automatic send_err(input int d, input int kind, input logic [63:0] opnd, input int n);
    exp_t e;
    e.op = 3'd0;
    e.opnd = partial(d, opnd, n);
    e.err = (kind == 2) ? 3'b100 : 3'b001;
    push_exp(d, e);
    for (int i = 0; i < n; i++) send_byte(d, 1'b0, opnd_byte(d, opnd, i), 1'b1);
    case (kind)
      0:       send_byte(d, 1'b1, 8'($urandom), 1'b1);
      1:       send_byte(d, 1'b0, 8'($urandom), 1'b1);
      default: begin
        send_byte(d, (n == 8), 8'($urandom), 1'b0);
        drive_bit(d, 1'b1);
      end
    endcase
  endtask

  initial begin
    int d, kind, n;
    logic [63:0] r_op;
    RST = 1'b1; sin_a = 1'b1; sin_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_ctrl_a", {vld_a, op_a, err_a, ovr_a, busy_a}, 64'd0);
    chk("rst_opnd_a", opnd_a, 64'd0);
    chk("rst_ctrl_b", {vld_b, op_b, err_b, ovr_b, busy_b}, 64'd0);
    chk("rst_opnd_b", opnd_b, 64'd0);
    #2 RST = 1'b0;
    idle(0, 2);

    // Clean command, valid one cycle after the CTL STOP.
    send_cmd(0, {32'h5, 32'h3}, 3'b100, 1'b0, 1'b1);
    @(negedge CLK);
    chk("t1_latency_valid", vld_a, 1'b1);
    idle(0, 3);
    chk("t1_valid_cleared", vld_a, 1'b0);

    // CRC error, operands still delivered.
    send_cmd(0, {32'h5, 32'h3}, 3'b100, 1'b1, 1'b1);
    idle(0, 2);

    // CTL after 6 DATA bytes, then a clean frame.
    send_err(0, 0, {32'h5, 32'h3}, 6);
    send_cmd(0, {32'hDEADBEEF, 32'h01234567}, 3'b010, 1'b0, 1'b1);
    idle(0, 2);

    // Framing error on byte 4, a clean frame, then reset mid byte 5.
    send_err(0, 2, {32'hA5A5A5A5, 32'h11223344}, 3);
    send_cmd(0, {32'h0, 32'hFFFFFFFF}, 3'b111, 1'b0, 1'b1);
    r_op = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) send_byte(0, 1'b0, opnd_byte(0, r_op, i), 1'b1);
    drive_bit(0, 1'b0); drive_bit(0, 1'b0);
    drive_bit(0, 1'b1); drive_bit(0, 1'b0); drive_bit(0, 1'b1);
    @(negedge CLK); #2; RST = 1'b1; sin_a = 1'b1;
    @(negedge CLK);
    chk("t4_busy_after_rst", busy_a, 1'b0);
    chk("t4_valid_after_rst", vld_a, 1'b0);
    #2 RST = 1'b0;
    idle(0, 20);
    chk("t4_no_cmd_after_abort", vld_a, 1'b0);

    // Backpressure: two back-to-back frames, second dropped.
    @(negedge CLK); #2; rdy_a = 1'b0;
    send_cmd(0, {32'h12345678, 32'h9ABCDEF0}, 3'b001, 1'b0, 1'b1);
    send_cmd(0, {32'h0BADF00D, 32'hCAFEBABE}, 3'b110, 1'b0, 1'b0);
    idle(0, 3);
    chk("t5_overrun_pulses", ovr_cnt_a, 1);
    chk("t5_valid_held", vld_a, 1'b1);
    @(negedge CLK); #2; rdy_a = 1'b1;
    @(negedge CLK);
    chk("t5_valid_after_accept", vld_a, 1'b0);
    chk("t5_queue_drained", exp_a.size(), 0);

    // 16x4 instance, directed operands.
    send_cmd(1, {16'h1234, 16'h8000, 16'h0001, 16'hFFFF}, 3'b011, 1'b0, 1'b1);
    idle(1, 2);

    // Randomized traffic on both instances.
    for (int it = 0; it < 40; it++) begin
      d = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      r_op = {$urandom, $urandom};
      case (kind)
        6: send_err(d, 0, r_op, $urandom_range(0, 7));
        7: send_err(d, 1, r_op, 8);
        8: begin
          n = $urandom_range(0, 8);
          send_err(d, 2, r_op, n);
        end
        default: send_cmd(d, r_op, 3'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
      endcase
      idle(d, $urandom_range(0, 2));
    end

    for (int i = 0; i < 200 && (exp_a.size() + exp_b.size()) > 0; i++) @(negedge CLK);
    chk("drain_a", exp_a.size(), 0);
    chk("drain_b", exp_b.size(), 0);
    chk("overrun_total_a", ovr_cnt_a, 1);
    chk("overrun_total_b", ovr_cnt_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
